// File: rtl/sad_pkg.sv
// Shared constants and types for the block-matching SAD pipeline.
// Holds the default geometry plus the row and block array types that the
// window loader produces and the tree adder consumes.
package sad_pkg;

  localparam int N_DEF      = 16;
  localparam int PIX_W_DEF  = 8;
  localparam int DIFF_W_DEF = 9;

  // One row of unsigned pixels, element 0 = column 0.
  typedef logic [N_DEF-1:0][PIX_W_DEF-1:0] pix_row_t;

  // Full block of signed differences, indexed [row][col].
  typedef logic signed [N_DEF-1:0][N_DEF-1:0][DIFF_W_DEF-1:0] diff_blk_t;

endpackage

// File: rtl/sad_row_diff.sv
// Combinational N-lane pixel subtractor producing one difference row.
// Build option: define SAD_WINDOW_ABS_DIFF_EN to emit |ref - cand| instead of
// the signed difference; output width is DIFF_W in both builds.
module sad_row_diff
  import sad_pkg::*;
#(
  parameter  int N      = N_DEF,
  parameter  int PIX_W  = PIX_W_DEF,
  localparam int DIFF_W = PIX_W + 1
) (
  input  logic [N-1:0][PIX_W-1:0]  row_ref,
  input  logic [N-1:0][PIX_W-1:0]  row_cand,
  output logic [N-1:0][DIFF_W-1:0] row_diff
);

  // Per-lane difference; one extra bit keeps the full -255..+255 range exact.
  always_comb begin
    row_diff = '0;
    for (int c = 0; c < N; c++) begin
`ifdef SAD_WINDOW_ABS_DIFF_EN
      if (row_ref[c] >= row_cand[c]) begin
        row_diff[c] = {1'b0, row_ref[c] - row_cand[c]};
      end else begin
        row_diff[c] = {1'b0, row_cand[c] - row_ref[c]};
      end
`else
      row_diff[c] = {1'b0, row_ref[c]} - {1'b0, row_cand[c]};
`endif
    end
  end

endmodule

// File: rtl/sad_window_loader.sv
// Ping-pong window loader in front of the SAD tree adder.
// Rows of reference/candidate pixels are differenced and written into the
// filling bank; a completed bank is presented, held stable, on out_diff until
// the consumer takes it. Build option SAD_WINDOW_ABS_DIFF_EN (see
// sad_row_diff) switches the stored value to the absolute difference.
module sad_window_loader
  import sad_pkg::*;
#(
  parameter  int N      = N_DEF,
  parameter  int PIX_W  = PIX_W_DEF,
  localparam int DIFF_W = PIX_W + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sof,
  input  logic [N-1:0][PIX_W-1:0]         in_ref,
  input  logic [N-1:0][PIX_W-1:0]         in_cand,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N-1:0][N-1:0][DIFF_W-1:0] out_diff,
  output logic                            err_misalign
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ONE_ROW  = CNT_W'(1);

  typedef logic [N-1:0][N-1:0][DIFF_W-1:0] bank_t;

  bank_t                     bank [2];
  logic [1:0]                full;
  logic                      fill_sel;
  logic                      drain_sel;
  logic [CNT_W-1:0]          row_cnt;

  logic [N-1:0][DIFF_W-1:0]  diff_row;
  logic                      accept;
  logic                      drain;
  logic                      early_sof;
  logic                      complete;
  logic [CNT_W-1:0]          wr_row;
  logic [CNT_W-1:0]          next_row;

  sad_row_diff #(
    .N     (N),
    .PIX_W (PIX_W)
  ) u_row_diff (
    .row_ref  (in_ref),
    .row_cand (in_cand),
    .row_diff (diff_row)
  );

  assign in_ready  = !full[fill_sel];
  assign out_valid = full[drain_sel];
  assign out_diff  = bank[drain_sel];

  // Beat qualification: an sof mid-block restarts the block at row 0.
  always_comb begin
    accept    = in_valid && in_ready;
    drain     = out_valid && out_ready;
    early_sof = accept && in_sof && (row_cnt != '0);
    wr_row    = early_sof ? '0 : row_cnt;
    complete  = accept && (wr_row == LAST_ROW);
    next_row  = complete ? '0 : (wr_row + ONE_ROW);
  end

  // Bank pointers, full flags, row counter and the sticky misalign flag.
  // Completion and drain never target the same bank, so both may fire together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full         <= '0;
      fill_sel     <= 1'b0;
      drain_sel    <= 1'b0;
      row_cnt      <= '0;
      err_misalign <= 1'b0;
    end else begin
      if (accept) begin
        row_cnt <= next_row;
      end
      if (complete) begin
        full[fill_sel] <= 1'b1;
        fill_sel       <= ~fill_sel;
      end
      if (drain) begin
        full[drain_sel] <= 1'b0;
        drain_sel       <= ~drain_sel;
      end
      if (early_sof) begin
        err_misalign <= 1'b1;
      end
    end
  end

  // Difference storage: each accepted beat lands in one row of the fill bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank[0] <= '0;
      bank[1] <= '0;
    end else if (accept) begin
      bank[fill_sel][wr_row] <= diff_row;
    end
  end

endmodule

// File: tb/tb_sad_window_loader.sv
// Self-checking bench for sad_window_loader: table-driven uniform blocks,
// hand-written stall / early-sof / reset sequences and a randomized ramp run,
// all checked against a block-level queue model kept in the bench.
module tb_sad_window_loader;
  import sad_pkg::*;

  localparam int N     = N_DEF;
  localparam int PIX_W = PIX_W_DEF;

  typedef struct {
    int ref_v;
    int cand_v;
    int exp_signed;
    int exp_abs;
  } vec_t;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      in_valid;
  logic      in_ready;
  logic      in_sof;
  pix_row_t  in_ref;
  pix_row_t  in_cand;
  logic      out_valid;
  logic      out_ready;
  diff_blk_t out_diff;
  logic      err_misalign;

  int tests = 0;
  int fails = 0;

  int ref_px  [N];
  int cand_px [N];
  int exp_q   [$];
  int part    [N*N];
  int model_row;
  bit model_err;
  int acc_count;
  int drain_count;
  bit last_acc;

  sad_window_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sof       (in_sof),
    .in_ref       (in_ref),
    .in_cand      (in_cand),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_diff     (out_diff),
    .err_misalign (err_misalign)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  function automatic int exp_diff(int r, int c);
`ifdef SAD_WINDOW_ABS_DIFF_EN
    return (r > c) ? (r - c) : (c - r);
`else
    return r - c;
`endif
  endfunction

  function automatic int dut_elem(int r, int c);
    return int'($signed(out_diff[r][c]));
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Compares the presented block against the oldest block in the model.
  task automatic checkOutput(input string name);
    int bad;
    int fr, fc, fa, fe;
    bad = 0; fr = 0; fc = 0; fa = 0; fe = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (dut_elem(r, c) != exp_q[r*N+c]) begin
          if (bad == 0) begin
            fr = r; fc = c; fa = dut_elem(r, c); fe = exp_q[r*N+c];
          end
          bad++;
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL %s: %0d bad elements, first [%0d][%0d] got %0d, expected %0d",
               name, bad, fr, fc, fa, fe);
    end
  endtask

  // Spec-level model of one accepted row: framing by its own row counter.
  task automatic model_accept(input bit sof);
    if (sof && model_row != 0) begin
      model_err = 1'b1;
      model_row = 0;
    end
    for (int c = 0; c < N; c++) part[model_row*N+c] = exp_diff(ref_px[c], cand_px[c]);
    model_row++;
    if (model_row == N) begin
      for (int i = 0; i < N*N; i++) exp_q.push_back(part[i]);
      model_row = 0;
    end
  endtask

  // Drives one cycle, checks handshake/output state against the model, then
  // advances both model and DUT across one clock edge.
  task automatic applyStimulus(input bit v, input bit sof, input bit rdy);
    bit exp_ready, exp_valid, acc, drn;
    in_valid  = v;
    in_sof    = sof;
    out_ready = rdy;
    for (int c = 0; c < N; c++) begin
      in_ref[c]  = PIX_W'(ref_px[c]);
      in_cand[c] = PIX_W'(cand_px[c]);
    end
    exp_valid = exp_q.size() > 0;
    exp_ready = exp_q.size() < 2*N*N;
    check("in_ready", int'(in_ready), int'(exp_ready));
    check("out_valid", int'(out_valid), int'(exp_valid));
    check("err_misalign", int'(err_misalign), int'(model_err));
    if (exp_valid) checkOutput("out_diff");
    last_acc = v && in_ready;
    if (last_acc) acc_count++;
    if (out_valid && rdy) drain_count++;
    acc = v && exp_ready;
    drn = rdy && exp_valid;
    if (drn) for (int i = 0; i < N*N; i++) void'(exp_q.pop_front());
    if (acc) model_accept(sof);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    int nz;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
    #1;
    nz = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (dut_elem(r, c) != 0) nz++;
    check("reset out_valid", int'(out_valid), 0);
    check("reset in_ready", int'(in_ready), 1);
    check("reset err_misalign", int'(err_misalign), 0);
    check("reset out_diff nonzero elems", nz, 0);
    exp_q.delete();
    model_row = 0;
    model_err = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic randRow();
    for (int c = 0; c < N; c++) begin
      ref_px[c]  = int'($urandom_range(0, 255));
      cand_px[c] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic drainAll(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      guard++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    vec_t vecs [5];
    int   snap, sum, bad, req, sent, gen_row, gen_blk, cyc;
    bit   v, rdy;

    vecs[0] = '{ref_v: 1,   cand_v: 0,   exp_signed: 1,    exp_abs: 1};
    vecs[1] = '{ref_v: 0,   cand_v: 255, exp_signed: -255, exp_abs: 255};
    vecs[2] = '{ref_v: 255, cand_v: 0,   exp_signed: 255,  exp_abs: 255};
    vecs[3] = '{ref_v: 100, cand_v: 100, exp_signed: 0,    exp_abs: 0};
    vecs[4] = '{ref_v: 7,   cand_v: 200, exp_signed: -193, exp_abs: 193};

    acc_count = 0; drain_count = 0; model_row = 0; model_err = 1'b0;
    for (int c = 0; c < N; c++) begin ref_px[c] = 0; cand_px[c] = 0; end
    in_ref = '0; in_cand = '0;
    doReset();

    // Uniform blocks: out_valid after the 16th beat, every element and the sum known.
    for (int k = 0; k < 5; k++) begin
`ifdef SAD_WINDOW_ABS_DIFF_EN
      req = vecs[k].exp_abs;
`else
      req = vecs[k].exp_signed;
`endif
      for (int c = 0; c < N; c++) begin ref_px[c] = vecs[k].ref_v; cand_px[c] = vecs[k].cand_v; end
      for (int r = 0; r < N; r++) applyStimulus(1'b1, r == 0, 1'b1);
      check("vec out_valid after last row", int'(out_valid), 1);
      sum = 0; bad = 0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          sum += dut_elem(r, c);
          if (dut_elem(r, c) != req) bad++;
        end
      check("vec bad elements", bad, 0);
      check("vec block sum", sum, req * N * N);
      applyStimulus(1'b0, 1'b0, 1'b1);
      check("vec out_valid after drain", int'(out_valid), 0);
    end

    // Back-pressure: two banks fill, the input stalls, one drain frees a bank.
    snap = acc_count;
    for (int b = 0; b < 40; b++) begin
      randRow();
      applyStimulus(1'b1, (b % N) == 0, 1'b0);
    end
    check("stall beats accepted", acc_count - snap, 2*N);
    check("stall in_ready", int'(in_ready), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("in_ready after one drain", int'(in_ready), 1);
    check("block 2 valid after drain", int'(out_valid), 1);
    drainAll("stall drain empty");

    // Early sof after 5 rows restarts the block and sets the sticky error.
    for (int r = 0; r < 5; r++) begin randRow(); applyStimulus(1'b1, r == 0, 1'b0); end
    randRow();
    applyStimulus(1'b1, 1'b1, 1'b0);
    check("err after early sof", int'(err_misalign), 1);
    for (int r = 1; r < N; r++) begin
      randRow();
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (r == N - 2) check("no block before 16th row", int'(out_valid), 0);
    end
    check("sof block complete", int'(out_valid), 1);
    drainAll("sof drain empty");
    check("err still sticky", int'(err_misalign), 1);

    // Reset with one block pending and a second block partly loaded.
    for (int r = 0; r < N + 10; r++) begin randRow(); applyStimulus(1'b1, (r % N) == 0, 1'b0); end
    check("pending before reset", int'(out_valid), 1);
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    snap = drain_count;
    for (int r = 0; r < N; r++) begin randRow(); applyStimulus(1'b1, r == 0, 1'b1); end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    check("blocks after reset", drain_count - snap, 1);

    // Random traffic: alternating ramp and random blocks, random handshakes.
    snap = drain_count; sent = 0; gen_row = 0; gen_blk = 0; cyc = 0;
    while (sent < 20 && cyc < 5000) begin
      for (int c = 0; c < N; c++) begin
        if (gen_blk % 2 == 0) begin
          ref_px[c]  = (gen_row * N + c) % 256;
          cand_px[c] = c;
        end else begin
          ref_px[c]  = int'($urandom_range(0, 255));
          cand_px[c] = int'($urandom_range(0, 255));
        end
      end
      v   = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 1) != 0;
      applyStimulus(v, gen_row == 0, rdy);
      if (last_acc) begin
        gen_row++;
        if (gen_row == N) begin gen_row = 0; gen_blk++; sent++; end
      end
      cyc++;
    end
    check("random blocks sent", sent, 20);
    drainAll("random drain empty");
    check("random blocks drained", drain_count - snap, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
